// File: rtl/frogger_disp_pkg.sv
// Shared types and defaults for the LED matrix scan path.
// Holds the scan state encoding and the frame geometry defaults.
package frogger_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;

    // LSB position of row r inside a flat ROWS*COLS frame word.
    function automatic int row_lsb(input int row, input int cols);
        return row * cols;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame-producer to matrix-scanner bus: pixel frame, update handshake, matrix drive.
// The producer side uses master, the scanner uses slave.
interface led_matrix_scan_if
    import frogger_disp_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);
    localparam int RW = $clog2(ROWS);

    logic [ROWS*COLS-1:0] pixel_rows;
    logic                 upd_req;
    logic                 upd_ack;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic                 frame_done;
    logic [RW-1:0]        cur_row;

    modport master (
        output pixel_rows, upd_req,
        input  upd_ack, row_sel, col_data, frame_done, cur_row
    );

    modport slave (
        input  pixel_rows, upd_req,
        output upd_ack, row_sel, col_data, frame_done, cur_row
    );

endinterface

// File: rtl/led_matrix_scan_timer.sv
// Row scan timing: BLANK/DRIVE phase counter and row index.
// Strobes mark the last cycle of a phase, the last row, and the frame wrap.
module scan_timer
    import frogger_disp_pkg::*;
#(
    parameter  int ROWS      = DEF_ROWS,
    parameter  int DWELL_CYC = 3125,
    parameter  int BLANK_CYC = 4,
    localparam int CW = $clog2(((BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC) + 1),
    localparam int RW = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    output scan_state_e   state_q,
    output logic [RW-1:0] row_q,
    output logic          phase_last,
    output logic          row_last,
    output logic          wrap
);

    logic [CW-1:0] phase_q;

    always_comb begin
        phase_last = (state_q == BLANK) ? (phase_q == CW'(BLANK_CYC - 1))
                                        : (phase_q == CW'(DWELL_CYC - 1));
        row_last   = (row_q == RW'(ROWS - 1));
        wrap       = (state_q == DRIVE) && phase_last && row_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK;
            phase_q <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (phase_last) begin
                        state_q <= DRIVE;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + CW'(1);
                    end
                end
                DRIVE: begin
                    if (phase_last) begin
                        state_q <= BLANK;
                        phase_q <= '0;
                        row_q   <= row_last ? '0 : row_q + RW'(1);
                    end else begin
                        phase_q <= phase_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= BLANK;
                    phase_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered LED matrix scanner: captures a full frame only at frame
// boundaries and drives it one row at a time with blanking between rows.
module led_matrix_scan
    import frogger_disp_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int DWELL_CYC = 3125,
    parameter int BLANK_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    led_matrix_scan_if.slave  bus
);

    localparam int RW = $clog2(ROWS);

    scan_state_e          state_q;
    logic [RW-1:0]        row_q;
    logic                 phase_last;
    logic                 row_last;
    logic                 wrap;

    logic                 pending_q, pending_d;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d;
    logic                 frame_done_q, frame_done_d;
    logic                 capture;
    logic [COLS-1:0]      shadow_rows [ROWS];

    scan_timer #(
        .ROWS      (ROWS),
        .DWELL_CYC (DWELL_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .state_q    (state_q),
        .row_q      (row_q),
        .phase_last (phase_last),
        .row_last   (row_last),
        .wrap       (wrap)
    );

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
            assign shadow_rows[gi] = shadow_q[row_lsb(gi, COLS) +: COLS];
        end
    endgenerate

    // A request arriving on the capture cycle itself is served immediately.
    always_comb begin
        capture      = wrap && (pending_q || bus.upd_req);
        pending_d    = capture ? 1'b0 : (pending_q || bus.upd_req);
        shadow_d     = capture ? bus.pixel_rows : shadow_q;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Matrix drive decodes registers only, so input changes never reach the pins directly.
    assign bus.row_sel    = (state_q == DRIVE) ? (ROWS'(1) << row_q) : '0;
    assign bus.col_data   = (state_q == DRIVE) ? shadow_rows[row_q] : '0;
    assign bus.upd_ack    = capture;
    assign bus.frame_done = frame_done_q;
    assign bus.cur_row    = row_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan (4x4, dwell 3, blank 1): directed vector table,
// hand sequences and random traffic against a cycle-count reference model.
module tb_led_matrix_scan;
    import frogger_disp_pkg::*;

    localparam int R   = 4;
    localparam int C   = 4;
    localparam int DW  = 3;
    localparam int BL  = 1;
    localparam int PER = BL + DW;
    localparam int FP  = R * PER;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_matrix_scan_if #(.ROWS(R), .COLS(C)) bus ();

    led_matrix_scan #(
        .ROWS(R), .COLS(C), .DWELL_CYC(DW), .BLANK_CYC(BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycle index since reset plus pending flag and shown frame.
    int          t = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_shadow = '0;
    bit          cur_rst = 1'b1;
    bit          cur_req = 1'b0;
    logic [15:0] cur_pix = '0;

    typedef struct {
        bit          rst;
        bit          req;
        logic [15:0] pix;
        logic [3:0]  rs;
        logic [3:0]  cd;
        bit          ack;
        bit          fd;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(bit rst, bit req, logic [15:0] pix,
                                logic [3:0] rs, logic [3:0] cd, bit ack, bit fd);
        vec_t v;
        v.rst = rst; v.req = req; v.pix = pix;
        v.rs = rs; v.cd = cd; v.ack = ack; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    // Advance one clock, apply new inputs, then compare all outputs to the model.
    task automatic step(input bit r, input bit q, input logic [15:0] p);
        int   row;
        int   ph;
        bit   drv;
        bit   cap;
        logic [3:0] e_rs;
        logic [3:0] e_cd;
        @(posedge clk);
        #1;
        if (cur_rst) begin
            t = 0; m_pend = 1'b0; m_shadow = '0;
        end else begin
            cap = (t % FP == FP - 1) && (m_pend || cur_req);
            if (cap) begin
                m_shadow = cur_pix;
                m_pend   = 1'b0;
            end else if (cur_req) begin
                m_pend = 1'b1;
            end
            t++;
        end
        cur_rst = r; cur_req = q; cur_pix = p;
        reset = r; bus.upd_req = q; bus.pixel_rows = p;
        #1;
        row  = (t / PER) % R;
        ph   = t % PER;
        drv  = (ph >= BL);
        e_rs = drv ? 4'(1 << row) : 4'h0;
        e_cd = drv ? 4'(m_shadow >> (row * C)) : 4'h0;
        chk("row_sel",    32'(bus.row_sel),    32'(e_rs));
        chk("col_data",   32'(bus.col_data),   32'(e_cd));
        chk("upd_ack",    32'(bus.upd_ack),    32'((t % FP == FP - 1) && (m_pend || cur_req)));
        chk("frame_done", 32'(bus.frame_done), 32'((t > 0) && (t % FP == 0)));
        chk("cur_row",    32'(bus.cur_row),    32'(row));
    endtask

    initial begin
        int acks;
        int lit;
        int guard;

        bus.upd_req = 1'b0;
        bus.pixel_rows = 16'hF96A;
        cur_pix = 16'hF96A;

        // Reset, first frame with a request in row 1, then the captured frame.
        tbl[0]  = mk(1, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[2]  = mk(0, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[3]  = mk(0, 0, 16'hF96A, 4'h1, 4'h0, 0, 0);
        tbl[4]  = mk(0, 0, 16'hF96A, 4'h1, 4'h0, 0, 0);
        tbl[5]  = mk(0, 0, 16'hF96A, 4'h1, 4'h0, 0, 0);
        tbl[6]  = mk(0, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[7]  = mk(0, 1, 16'hF96A, 4'h2, 4'h0, 0, 0);
        tbl[8]  = mk(0, 0, 16'hF96A, 4'h2, 4'h0, 0, 0);
        tbl[9]  = mk(0, 0, 16'hF96A, 4'h2, 4'h0, 0, 0);
        tbl[10] = mk(0, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[11] = mk(0, 0, 16'hF96A, 4'h4, 4'h0, 0, 0);
        tbl[12] = mk(0, 0, 16'hF96A, 4'h4, 4'h0, 0, 0);
        tbl[13] = mk(0, 0, 16'hF96A, 4'h4, 4'h0, 0, 0);
        tbl[14] = mk(0, 0, 16'hF96A, 4'h0, 4'h0, 0, 0);
        tbl[15] = mk(0, 0, 16'hF96A, 4'h8, 4'h0, 0, 0);
        tbl[16] = mk(0, 0, 16'hF96A, 4'h8, 4'h0, 0, 0);
        tbl[17] = mk(0, 0, 16'hF96A, 4'h8, 4'h0, 1, 0);
        tbl[18] = mk(0, 0, 16'h0000, 4'h0, 4'h0, 0, 1);
        tbl[19] = mk(0, 0, 16'h0000, 4'h1, 4'hA, 0, 0);
        tbl[20] = mk(0, 0, 16'h0000, 4'h1, 4'hA, 0, 0);
        tbl[21] = mk(0, 0, 16'h0000, 4'h1, 4'hA, 0, 0);
        tbl[22] = mk(0, 0, 16'h0000, 4'h0, 4'h0, 0, 0);
        tbl[23] = mk(0, 0, 16'h0000, 4'h2, 4'h6, 0, 0);
        tbl[24] = mk(0, 0, 16'h0000, 4'h2, 4'h6, 0, 0);
        tbl[25] = mk(0, 0, 16'h0000, 4'h2, 4'h6, 0, 0);
        tbl[26] = mk(0, 0, 16'h0000, 4'h0, 4'h0, 0, 0);
        tbl[27] = mk(0, 0, 16'h0000, 4'h4, 4'h9, 0, 0);
        tbl[28] = mk(0, 0, 16'h0000, 4'h4, 4'h9, 0, 0);
        tbl[29] = mk(0, 0, 16'h0000, 4'h4, 4'h9, 0, 0);
        tbl[30] = mk(0, 0, 16'h0000, 4'h0, 4'h0, 0, 0);
        tbl[31] = mk(0, 0, 16'h0000, 4'h8, 4'hF, 0, 0);
        tbl[32] = mk(0, 0, 16'h0000, 4'h8, 4'hF, 0, 0);
        tbl[33] = mk(0, 0, 16'h0000, 4'h8, 4'hF, 0, 0);

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].pix);
            chk("tbl_row_sel",    32'(bus.row_sel),    32'(tbl[i].rs));
            chk("tbl_col_data",   32'(bus.col_data),   32'(tbl[i].cd));
            chk("tbl_upd_ack",    32'(bus.upd_ack),    32'(tbl[i].ack));
            chk("tbl_frame_done", 32'(bus.frame_done), 32'(tbl[i].fd));
        end

        // Another full frame with changed input and no request: display must hold.
        lit = 0;
        for (int i = 0; i < FP; i++) begin
            step(0, 0, 16'h0000);
            if (bus.row_sel == 4'h1 && bus.col_data == 4'hA) lit++;
        end
        chk("hold_row0_A_cycles", 32'(lit), 32'(DW));

        // Request held for 20 cycles straddling one boundary, data changing each cycle.
        guard = 0;
        while (t % FP != FP / 2 - 1 && guard < 2 * FP) begin
            step(0, 0, 16'h0000);
            guard++;
        end
        chk("align_held_req", 32'(t % FP), 32'(FP / 2 - 1));
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 16'($urandom));
            if (bus.upd_ack) acks++;
        end
        chk("held_req_acks", 32'(acks), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        // Reset during row 2 drive with a request pending: everything discarded.
        guard = 0;
        while (t % FP != FP - 1 && guard < 2 * FP) begin
            step(0, 0, 16'hFFFF);
            guard++;
        end
        step(0, 1, 16'hFFFF);
        guard = 0;
        while (t % FP != 2 * PER + BL && guard < 2 * FP) begin
            step(0, 0, 16'hFFFF);
            guard++;
        end
        chk("row2_drive_reached", 32'(bus.row_sel), 32'h4);
        step(1, 0, 16'hFFFF);
        step(0, 0, 16'hFFFF);
        chk("rst_mid_row_sel",  32'(bus.row_sel),  32'h0);
        chk("rst_mid_col_data", 32'(bus.col_data), 32'h0);
        chk("rst_mid_cur_row",  32'(bus.cur_row),  32'h0);
        acks = 0;
        lit  = 0;
        for (int i = 0; i < 2 * FP + 4; i++) begin
            step(0, 0, 16'hFFFF);
            if (bus.upd_ack) acks++;
            if (bus.col_data != 4'h0) lit++;
        end
        chk("post_rst_acks",    32'(acks), 32'd0);
        chk("post_rst_lit_cyc", 32'(lit),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
